rom_streamer: RTL
=================

// Module: rom_streamer
// PURPOSE
//   Burst reader in front of the synchronous ROM (1-cycle registered read). Drives ROM address,
//   captures ROM data, presents it as a valid/ready stream with last flag. Sits between control
//   logic (start/base/length) and any stream consumer. Full throughput (1 word/clk) when m_ready_i=1.
// PARAMETERS
//   DATA_WIDTH  8  ROM word width; equals ROM DATA_WIDTH
//   ADDR_WIDTH  8  ROM address width; equals ROM ADDR_WIDTH
// PORTS
//   clk_i        in   1             clock; all logic on posedge
//   rst_i        in   1             synchronous, active-high reset
//   start_i      in   1             burst request; sampled only in IDLE
//   base_addr_i  in   ADDR_WIDTH    first ROM address; sampled with start_i
//   length_i     in   ADDR_WIDTH+1  words in burst, 0..2**ADDR_WIDTH; sampled with start_i
//   busy_o       out  1             high from the cycle after start is accepted until done_o
//   done_o       out  1             1-cycle pulse after the last beat is accepted
//   rom_addr_o   out  ADDR_WIDTH    to ROM addr_i; registered
//   rom_data_i   in   DATA_WIDTH    from ROM data_o; valid 1 clk after address captured
//   m_data_o     out  DATA_WIDTH    stream data
//   m_valid_o    out  1             stream valid
//   m_ready_i    in   1             stream ready; beat transfers when valid&&ready
//   m_last_o     out  1             high with final beat of burst
// BEHAVIOUR
//   - Reset: busy_o=0, done_o=0, m_valid_o=0, m_last_o=0, rom_addr_o=0, FIFO empty, pending=0,
//     state IDLE. Reset mid-burst aborts: in-flight ROM data discarded, no done_o.
//   - FSM: IDLE -(start_i, length!=0)-> RUN; IDLE -(start_i, length==0)-> DONE (no beats);
//     RUN -(all words issued)-> DRAIN; DRAIN -(FIFO empty && !pending)-> DONE; DONE -> IDLE (1 clk,
//     done_o=1). start_i outside IDLE ignored.
//   - Accept edge: rom_addr_o<=base_addr_i, remaining<=length_i.
//   - Issue: in RUN, cycle is an issue when fifo_count + pending - pop < 2 (pop = valid&&ready);
//     ROM captures rom_addr_o at that edge; rom_addr_o increments, wraps mod 2**ADDR_WIDTH
//     (base 0xFE, len 4 -> FE,FF,00,01); remaining decrements.
//   - pending<=issue; when pending=1, rom_data_i pushed into 2-entry FIFO at next edge.
//   - FIFO never overflows by issue rule; simultaneous push/pop keeps count. m_data_o/m_valid_o
//     from FIFO head; data held stable while valid&&!ready.
//   - m_last_o: head entry is the burst's final word (tag stored per FIFO entry).
//   - Latency: first m_valid_o high 2 clocks after start-accept edge. m_ready_i=1 -> N beats on
//     N consecutive cycles; done_o 1 clk after last transfer.
// CONFIGURATION
//   ROM_STREAMER_CHECKSUM_EN defined: extra port checksum_o out DATA_WIDTH = wrapping sum (mod
//     2**DATA_WIDTH) of beats transferred this burst; cleared on start accept and reset; final
//     value valid with done_o, held until next start.
//   Undefined: no checksum_o port, no adder logic.
// STRUCTURE
//   rom_streamer_pkg: state_t enum {IDLE,RUN,DRAIN,DONE}; FIFO_DEPTH=2 constant.
//   Sub-module stream_fifo2: 2-entry sync FIFO {data,last}, push/pop/count, synchronous reset.
// TESTING (ROM init: mem[i]=i, ADDR_WIDTH=8, DATA_WIDTH=8)
//   base=0x10 len=4 ready=1 -> data 10,11,12,13 on 4 consecutive cycles, last on 13, done_o 1 clk later
//   base=0xFE len=4 -> 0xFE,0xFF,0x00,0x01; checksum_o=0xFE (when CHECKSUM_EN)
//   len=0 -> no m_valid_o; done_o pulses; busy_o high 1 clk
//   base=0 len=8, ready toggles 1,0,0,1,... -> all 0..7 in order, no loss/dup, data stable when stalled
//   start_i pulsed while busy -> ignored; rst_i mid-burst -> outputs return to reset values next clk
//   len=256 base=0x80 ready=1 -> 256 beats 80..7F, single last, done_o once

Source files
------------

// File: rtl/rom_streamer_pkg.sv
// Shared types and constants for the ROM burst streamer and its output FIFO.
package rom_streamer_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    typedef logic [1:0] fifo_cnt_t;

    localparam fifo_cnt_t FIFO_DEPTH = 2'd2;

    // Words that will occupy the FIFO after this edge if no further issue happens.
    function automatic logic [2:0] occupancy(fifo_cnt_t cnt, logic pend, logic pop);
        return {1'b0, cnt} + 3'(pend) - 3'(pop);
    endfunction

endpackage

// File: rtl/rom_streamer_stream_fifo2.sv
// Two-entry synchronous FIFO carrying a data word plus its end-of-burst tag.
module stream_fifo2
    import rom_streamer_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  push_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  last_i,
    input  logic                  pop_i,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  last_o,
    output fifo_cnt_t             count_o,
    output logic                  empty_o
);

    logic [DATA_WIDTH-1:0] data_q [FIFO_DEPTH];
    logic                  last_q [FIFO_DEPTH];
    logic                  wr_ptr_q;
    logic                  rd_ptr_q;
    fifo_cnt_t             count_q;
    fifo_cnt_t             count_d;
    logic                  push_ok;
    logic                  pop_ok;

    assign push_ok = push_i && (count_q != FIFO_DEPTH);
    assign pop_ok  = pop_i && (count_q != 2'd0);

    always_comb begin
        count_d = count_q;
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (push_ok) begin
                wr_ptr_q <= ~wr_ptr_q;
            end
            if (pop_ok) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_d;
        end
    end

    // Storage is not reset; the count alone decides what is visible.
    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            data_q[wr_ptr_q] <= data_i;
            last_q[wr_ptr_q] <= last_i;
        end
    end

    assign data_o  = data_q[rd_ptr_q];
    assign last_o  = last_q[rd_ptr_q];
    assign count_o = count_q;
    assign empty_o = (count_q == 2'd0);

endmodule

// File: rtl/rom_streamer.sv
// Burst reader: drives a 1-cycle-latency ROM and streams the words out as valid/ready with last.
// Optional feature macro: ROM_STREAMER_CHECKSUM_EN adds checksum_o (wrapping sum of transferred beats).
module rom_streamer
    import rom_streamer_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic [ADDR_WIDTH-1:0] base_addr_i,
    input  logic [ADDR_WIDTH:0]   length_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [ADDR_WIDTH-1:0] rom_addr_o,
    input  logic [DATA_WIDTH-1:0] rom_data_i,
    output logic [DATA_WIDTH-1:0] m_data_o,
    output logic                  m_valid_o,
    input  logic                  m_ready_i,
    output logic                  m_last_o
`ifdef ROM_STREAMER_CHECKSUM_EN
    ,
    output logic [DATA_WIDTH-1:0] checksum_o
`endif
);

    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = 1;
    localparam logic [ADDR_WIDTH:0]   REM_ONE  = 1;

    state_t                state_q;
    logic [ADDR_WIDTH-1:0] rom_addr_q;
    logic [ADDR_WIDTH:0]   remaining_q;
    logic                  pending_q;
    logic                  pending_last_q;
    logic                  busy_q;
    logic                  done_q;

    logic [DATA_WIDTH-1:0] fifo_data;
    logic                  fifo_last;
    fifo_cnt_t             fifo_count;
    logic                  fifo_empty;

    logic                  pop;
    logic                  accept;
    logic                  issue;
    logic                  last_issue;
    logic                  drain_done;

    assign m_valid_o = !fifo_empty;
    assign pop       = m_valid_o && m_ready_i;
    assign accept    = (state_q == IDLE) && start_i;

    // Issue only if the word cannot overflow the FIFO when it lands next cycle.
    assign issue      = (state_q == RUN) && (occupancy(fifo_count, pending_q, pop) < 3'd2);
    assign last_issue = issue && (remaining_q == REM_ONE);

    // Looks past the current edge so done_o follows the last transfer by one cycle.
    assign drain_done = !pending_q &&
                        ((fifo_count == 2'd0) || ((fifo_count == 2'd1) && pop));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q        <= IDLE;
            rom_addr_q     <= '0;
            remaining_q    <= '0;
            pending_q      <= 1'b0;
            pending_last_q <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
        end else begin
            pending_q      <= issue;
            pending_last_q <= last_issue;
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        rom_addr_q  <= base_addr_i;
                        remaining_q <= length_i;
                        busy_q      <= 1'b1;
                        if (length_i == '0) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (issue) begin
                        rom_addr_q  <= rom_addr_q + ADDR_ONE;
                        remaining_q <= remaining_q - REM_ONE;
                        if (last_issue) begin
                            state_q <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (drain_done) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    stream_fifo2 #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_fifo (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .push_i (pending_q),
        .data_i (rom_data_i),
        .last_i (pending_last_q),
        .pop_i  (pop),
        .data_o (fifo_data),
        .last_o (fifo_last),
        .count_o(fifo_count),
        .empty_o(fifo_empty)
    );

    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign rom_addr_o = rom_addr_q;
    assign m_data_o   = fifo_data;
    assign m_last_o   = fifo_last && m_valid_o;

`ifdef ROM_STREAMER_CHECKSUM_EN
    logic [DATA_WIDTH-1:0] checksum_q;
    logic [DATA_WIDTH-1:0] checksum_d;

    always_comb begin
        checksum_d = checksum_q;
        if (accept) begin
            checksum_d = '0;
        end else if (pop) begin
            checksum_d = checksum_q + m_data_o;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            checksum_q <= '0;
        end else begin
            checksum_q <= checksum_d;
        end
    end

    assign checksum_o = checksum_q;
`endif

endmodule
